// File: rtl/ex_stage.sv
// Execute stage: ALU with signed-overflow detection, iterative shift-add
// multiplier with busy handshake, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  input  logic [29:0] id_pc,
  input  logic        id_en_,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_alu_in_0,
  input  logic [31:0] id_alu_in_1,
  input  logic        id_br_flag,
  input  logic [1:0]  id_mem_op,
  input  logic [31:0] id_mem_wr_data,
  input  logic [1:0]  id_ctrl_op,
  input  logic [4:0]  id_dst_addr,
  input  logic        id_gpr_we_,
  input  logic [2:0]  id_exp_code,
  output logic [31:0] ex_fwd_data,
  output logic [29:0] ex_pc,
  output logic        ex_en_,
  output logic        ex_br_flag,
  output logic [1:0]  ex_mem_op,
  output logic [31:0] ex_mem_wr_data,
  output logic [1:0]  ex_ctrl_op,
  output logic [4:0]  ex_dst_addr,
  output logic        ex_gpr_we_,
  output logic [2:0]  ex_exp_code,
  output logic [31:0] ex_out
);

  localparam int unsigned CW = $clog2(MUL_CYCLES) + 1;
  localparam logic [3:0] OP_ADDS = 4'd4;
  localparam logic [3:0] OP_SUBS = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  mul_state_t    state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_start;

  logic [31:0] sum, diff, alu_res;
  logic        ovf;
  logic [2:0]  exp_code;

  logic [29:0] pc_q, pc_d;
  logic        en_q, en_d, br_q, br_d, we_q, we_d;
  logic [1:0]  mem_op_q, mem_op_d, ctrl_op_q, ctrl_op_d;
  logic [31:0] wr_data_q, wr_data_d, out_q, out_d;
  logic [4:0]  dst_q, dst_d;
  logic [2:0]  exp_q, exp_d;

  assign sum  = id_alu_in_0 + id_alu_in_1;
  assign diff = id_alu_in_0 - id_alu_in_1;

  // ALU result and overflow for the instruction currently in EX
  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (id_alu_op)
      4'd0:  alu_res = id_alu_in_0;
      4'd1:  alu_res = id_alu_in_0 & id_alu_in_1;
      4'd2:  alu_res = id_alu_in_0 | id_alu_in_1;
      4'd3:  alu_res = id_alu_in_0 ^ id_alu_in_1;
      4'd4, 4'd5: alu_res = sum;
      4'd6, 4'd7: alu_res = diff;
      4'd8:  alu_res = id_alu_in_0 >> id_alu_in_1[4:0];
      4'd9:  alu_res = id_alu_in_0 << id_alu_in_1[4:0];
      4'd10: alu_res = acc_q;
      default: alu_res = '0;
    endcase
    if (!id_en_) begin
      if (id_alu_op == OP_ADDS)
        ovf = (id_alu_in_0[31] == id_alu_in_1[31]) && (sum[31] != id_alu_in_0[31]);
      else if (id_alu_op == OP_SUBS)
        ovf = (id_alu_in_0[31] != id_alu_in_1[31]) && (diff[31] != id_alu_in_0[31]);
    end
    if (id_exp_code != 3'd0) exp_code = id_exp_code;
    else if (ovf)            exp_code = EXP_OVERFLOW;
    else                     exp_code = 3'd0;
  end

  assign ex_fwd_data = alu_res;

  // reset is folded in so busy drops the instant reset is applied
  assign mul_start = !id_en_ && (id_alu_op == OP_MUL) && !flush && !reset;

  // Multiplier next-state, datapath and busy
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mul_start) begin
          busy    = 1'b1;
          a_d     = id_alu_in_0;
          b_d     = id_alu_in_1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Multiplier state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX/MEM next value: flush bubble beats stall hold beats load
  always_comb begin
    pc_d      = pc_q;
    en_d      = en_q;
    br_d      = br_q;
    mem_op_d  = mem_op_q;
    wr_data_d = wr_data_q;
    ctrl_op_d = ctrl_op_q;
    dst_d     = dst_q;
    we_d      = we_q;
    exp_d     = exp_q;
    out_d     = out_q;
    if (flush) begin
      pc_d      = '0;
      en_d      = 1'b1;
      br_d      = 1'b0;
      mem_op_d  = '0;
      wr_data_d = '0;
      ctrl_op_d = '0;
      dst_d     = '0;
      we_d      = 1'b1;
      exp_d     = '0;
      out_d     = '0;
    end else if (!stall) begin
      pc_d      = id_pc;
      en_d      = id_en_;
      br_d      = id_br_flag;
      mem_op_d  = id_mem_op;
      wr_data_d = id_mem_wr_data;
      ctrl_op_d = id_ctrl_op;
      dst_d     = id_dst_addr;
      we_d      = id_gpr_we_ | ovf;
      exp_d     = exp_code;
      out_d     = alu_res;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      en_q      <= 1'b1;
      br_q      <= 1'b0;
      mem_op_q  <= '0;
      wr_data_q <= '0;
      ctrl_op_q <= '0;
      dst_q     <= '0;
      we_q      <= 1'b1;
      exp_q     <= '0;
      out_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      en_q      <= en_d;
      br_q      <= br_d;
      mem_op_q  <= mem_op_d;
      wr_data_q <= wr_data_d;
      ctrl_op_q <= ctrl_op_d;
      dst_q     <= dst_d;
      we_q      <= we_d;
      exp_q     <= exp_d;
      out_q     <= out_d;
    end
  end

  assign ex_pc          = pc_q;
  assign ex_en_         = en_q;
  assign ex_br_flag     = br_q;
  assign ex_mem_op      = mem_op_q;
  assign ex_mem_wr_data = wr_data_q;
  assign ex_ctrl_op     = ctrl_op_q;
  assign ex_dst_addr    = dst_q;
  assign ex_gpr_we_     = we_q;
  assign ex_exp_code    = exp_q;
  assign ex_out         = out_q;

endmodule
